// File: rtl/led_fader_pkg.sv
// Shared constants for the LED fader: brightness width, full level and last PWM count.
package led_fader_pkg;

  localparam int          LVL_W    = 4;
  localparam logic [3:0]  LVL_MAX  = 4'd15;
  localparam logic [3:0]  PWM_LAST = 4'd14;

endpackage

// File: rtl/led_fader_tick_div.sv
// Free-running modulo-DIV counter producing a one-cycle pulse on its last count.
module tick_div #(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic resetn,
  output logic tick
);

  localparam int unsigned       CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_reg <= '0;
    end else if (cnt_reg == LAST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // DIV=1 keeps the counter at zero, so the pulse is asserted every cycle.
  assign tick = (cnt_reg == LAST);

endmodule

// File: rtl/led_fader.sv
// LED output stage: full brightness while the pattern bit is set, then a linear
// 16-step PWM fade-out once it drops (or an immediate off when fading is disabled).
module led_fader
  import led_fader_pkg::*;
#(
  parameter int         WIDTH     = 16,
  parameter logic [26:0] PWM_DIV   = 27'd100,
  parameter logic [26:0] DECAY_DIV = 27'd6_250_000
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] pat_in,
  input  logic             fade_en,
  output logic [WIDTH-1:0] led_out
);

  logic             pwm_step;
  logic             decay_tick;
  logic [LVL_W-1:0] pwm_cnt_reg;

  tick_div #(.DIV(int'(PWM_DIV))) u_pwm_pre (
    .clk    (clk),
    .resetn (resetn),
    .tick   (pwm_step)
  );

  tick_div #(.DIV(int'(DECAY_DIV))) u_decay_pre (
    .clk    (clk),
    .resetn (resetn),
    .tick   (decay_tick)
  );

  // PWM compare counter stops at 14 so level 15 is lit for the whole frame.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pwm_cnt_reg <= '0;
    end else if (pwm_step) begin
      pwm_cnt_reg <= (pwm_cnt_reg == PWM_LAST) ? '0 : pwm_cnt_reg + 1'b1;
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
    logic [LVL_W-1:0] level_reg;
    logic             led_reg;

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        level_reg <= '0;
        led_reg   <= 1'b0;
      end else begin
        led_reg <= (level_reg > pwm_cnt_reg);
        // A set pattern bit overrides a coincident decay tick.
        if (pat_in[gi]) begin
          level_reg <= LVL_MAX;
        end else if (!fade_en) begin
          level_reg <= '0;
        end else if (decay_tick && (level_reg != '0)) begin
          level_reg <= level_reg - 1'b1;
        end
      end
    end

    assign led_out[gi] = led_reg;
  end

endmodule

// File: tb/tb_led_fader.sv
// Self-checking bench for led_fader with a cycle-level reference model feeding a scoreboard.
module tb_led_fader;

  localparam int WIDTH        = 16;
  localparam int PWM_DIV_TB   = 1;
  localparam int DECAY_DIV_TB = 4;

  logic             clk;
  logic             resetn;
  logic [WIDTH-1:0] pat_in;
  logic             fade_en;
  logic [WIDTH-1:0] led_out;

  int checks = 0;
  int errors = 0;
  bit sb_en  = 0;

  led_fader #(
    .WIDTH     (WIDTH),
    .PWM_DIV   (27'(PWM_DIV_TB)),
    .DECAY_DIV (27'(DECAY_DIV_TB))
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .pat_in  (pat_in),
    .fade_en (fade_en),
    .led_out (led_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: pwm counter steps every cycle (PWM_DIV=1), decay every DECAY_DIV_TB cycles.
  int m_pwm = 0;
  int m_dec = 0;
  int m_level [WIDTH];
  logic [WIDTH-1:0] exp_q [$];

  function automatic logic [WIDTH-1:0] model_led();
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) r[i] = (m_level[i] > m_pwm);
    return r;
  endfunction

  function automatic int model_level_next(int i);
    if (pat_in[i]) return 15;
    if (!fade_en) return 0;
    if ((m_dec == DECAY_DIV_TB - 1) && (m_level[i] > 0)) return m_level[i] - 1;
    return m_level[i];
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_pwm <= 0;
      m_dec <= 0;
      for (int i = 0; i < WIDTH; i++) m_level[i] <= 0;
      exp_q.delete();
    end else begin
      exp_q.push_back(model_led());
      for (int i = 0; i < WIDTH; i++) m_level[i] <= model_level_next(i);
      m_pwm <= (m_pwm == 14) ? 0 : m_pwm + 1;
      m_dec <= (m_dec == DECAY_DIV_TB - 1) ? 0 : m_dec + 1;
    end
  end

  // Scoreboard: one expected word per clock edge, compared mid-cycle.
  always @(negedge clk) begin
    logic [WIDTH-1:0] exp_v;
    if (sb_en && resetn && (exp_q.size() > 0)) begin
      exp_v = exp_q.pop_front();
      checks++;
      if (led_out !== exp_v) begin
        errors++;
        $display("FAIL scoreboard t=%0t led_out=%h expected=%h", $time, led_out, exp_v);
      end
    end
  end

  task automatic test_reset();
    resetn  = 1'b1;
    pat_in  = 16'hffff;
    fade_en = 1'b1;
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (led_out !== 16'h0000) begin
      errors++;
      $display("FAIL reset_initial led_out=%h expected=0000", led_out);
    end
    @(negedge clk);
    resetn = 1'b1;
    sb_en  = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (led_out !== 16'hffff) begin
      errors++;
      $display("FAIL reset_prelit led_out=%h expected=ffff", led_out);
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (led_out !== 16'h0000) begin
      errors++;
      $display("FAIL reset_async led_out=%h expected=0000", led_out);
    end
    pat_in = 16'h0000;
    #1 resetn = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (led_out !== 16'h0000) begin
        errors++;
        $display("FAIL reset_release cycle=%0d led_out=%h expected=0000", c, led_out);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_steady_on();
    logic [WIDTH-1:0] want;
    @(negedge clk);
    pat_in  = 16'h0001;
    fade_en = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      @(negedge clk);
      want = (e >= 2) ? 16'h0001 : 16'h0000;
      checks++;
      if (led_out !== want) begin
        errors++;
        $display("FAIL steady_on edge=%0d led_out=%h expected=%h", e, led_out, want);
      end
    end
    $display("test_steady_on done");
  endtask

  task automatic test_fade();
    int win_cnt  = 0;
    int prev_win = 1000;
    repeat (20) @(negedge clk);
    pat_in = 16'h0000;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (led_out[0]) win_cnt++;
      if ((c % 15) == 0 && c <= 75) begin
        checks++;
        if (win_cnt > prev_win || (c == 15 && win_cnt < 10)) begin
          errors++;
          $display("FAIL fade_window end=%0d ones=%0d previous=%0d", c, win_cnt, prev_win);
        end
        prev_win = win_cnt;
        win_cnt  = 0;
      end
      if (c >= 64) begin
        checks++;
        if (led_out !== 16'h0000) begin
          errors++;
          $display("FAIL fade_off cycle=%0d led_out=%h expected=0000", c, led_out);
        end
      end
    end
    $display("test_fade done");
  endtask

  task automatic test_no_fade();
    @(negedge clk);
    fade_en = 1'b0;
    pat_in  = 16'h8000;
    repeat (4) @(negedge clk);
    checks++;
    if (led_out !== 16'h8000) begin
      errors++;
      $display("FAIL nofade_on led_out=%h expected=8000", led_out);
    end
    pat_in = 16'h0000;
    @(negedge clk);
    checks++;
    if (led_out[15] !== 1'b1) begin
      errors++;
      $display("FAIL nofade_edge1 led_out[15]=%b expected=1", led_out[15]);
    end
    @(negedge clk);
    checks++;
    if (led_out[15] !== 1'b0) begin
      errors++;
      $display("FAIL nofade_edge2 led_out[15]=%b expected=0", led_out[15]);
    end
    $display("test_no_fade done");
  endtask

  task automatic test_retrigger();
    bit done = 1'b0;
    fade_en = 1'b1;
    for (int a = 0; a < 15 && !done; a++) begin
      @(negedge clk);
      pat_in = 16'h0001;
      repeat (20 + a) @(negedge clk);
      pat_in = 16'h0000;
      for (int c = 0; c < 80 && !done; c++) begin
        @(negedge clk);
        // Next edge is a decay tick at level 7; pick a phase where level 6 would show dark.
        if (m_level[0] == 7 && m_dec == DECAY_DIV_TB - 1 && ((m_pwm + 1) % 15) >= 6) begin
          pat_in = 16'h0001;
          @(negedge clk);
          @(negedge clk);
          checks++;
          if (led_out[0] !== 1'b1) begin
            errors++;
            $display("FAIL retrigger led_out[0]=%b expected=1", led_out[0]);
          end
          done = 1'b1;
        end
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL retrigger_setup found=%b expected=1", done);
    end
    pat_in = 16'h0000;
    repeat (70) @(negedge clk);
    $display("test_retrigger done");
  endtask

  task automatic test_rotation();
    logic [WIDTH-1:0] pat;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] newly;
    pat     = 16'hfffe;
    prev    = pat_in;
    fade_en = 1'b1;
    for (int r = 0; r < 8; r++) begin
      @(negedge clk);
      pat_in = pat;
      newly  = pat & ~prev;
      for (int c = 1; c <= 8; c++) begin
        if (c > 1) @(negedge clk);
        if (c == 1) @(negedge clk);
        if (c == 2) begin
          checks++;
          if ((led_out & newly) !== newly) begin
            errors++;
            $display("FAIL rotation step=%0d led_out=%h required_set=%h", r, led_out, newly);
          end
        end
      end
      prev = pat;
      pat  = {pat[WIDTH-2:0], pat[WIDTH-1]};
    end
    $display("test_rotation done");
  endtask

  initial begin
    test_reset();
    test_steady_on();
    test_fade();
    test_no_fade();
    test_retrigger();
    test_rotation();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time=%0t limit=500000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
